// File: rtl/sha256_unpad.sv
// SHA-256 single-block unpadder: validates the 0x80 marker, zero fill and 64-bit
// length field of a padded 512-bit block, then streams the message bytes out.
module sha256_unpad #(
  parameter int MAX_MSG_BYTES = 55,
  parameter bit CHECK_ZEROS   = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         blk_valid,
  input  logic [511:0] padd_in,
  output logic         blk_ready,
  output logic [7:0]   data_out,
  output logic         data_valid,
  input  logic         data_ready,
  output logic         data_last,
  output logic         done,
  output logic         pad_err,
  output logic [5:0]   msg_len,
  output logic [1:0]   state_dbg
);

  // Byte stream handshake: a byte transfers on a rising edge where data_valid
  // and data_ready are both high; data_out/data_last hold while data_valid is
  // high and data_ready is low. Blocks transfer when blk_valid and blk_ready are high.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    STREAM = 2'd2
  } state_t;

  state_t       state;
  logic [511:0] blk;
  logic [5:0]   cnt;
  logic [5:0]   n_bytes;
  logic         pad_ok;

  assign state_dbg = state;

  function automatic logic [7:0] byte_at(input logic [511:0] b, input logic [5:0] idx);
    logic [511:0] sh;
    sh = b << {idx, 3'b000};
    return sh[511:504];
  endfunction

  always_comb begin
    n_bytes = blk[8:3];
    pad_ok  = 1'b1;
    if (blk[2:0] != 3'd0) pad_ok = 1'b0;
    if (|blk[63:9]) pad_ok = 1'b0;
    if (int'(n_bytes) > MAX_MSG_BYTES) pad_ok = 1'b0;
    if (byte_at(blk, n_bytes) != 8'h80) pad_ok = 1'b0;
    // Every byte after the marker up to the length field must be zero.
    if (CHECK_ZEROS) begin
      for (int i = 0; i < 56; i++) begin
        if (i > int'(n_bytes) && blk[511-8*i -: 8] != 8'h00) pad_ok = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      blk        <= '0;
      cnt        <= '0;
      blk_ready  <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      data_last  <= 1'b0;
      done       <= 1'b0;
      pad_err    <= 1'b0;
      msg_len    <= '0;
    end else begin
      done    <= 1'b0;
      pad_err <= 1'b0;
      case (state)
        IDLE: begin
          if (blk_valid && blk_ready) begin
            blk       <= padd_in;
            blk_ready <= 1'b0;
            state     <= CHECK;
          end else begin
            blk_ready <= 1'b1;
          end
        end
        CHECK: begin
          msg_len <= n_bytes;
          cnt     <= '0;
          if (!pad_ok) begin
            pad_err <= 1'b1;
            state   <= IDLE;
          end else if (n_bytes == 6'd0) begin
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            data_valid <= 1'b1;
            data_out   <= byte_at(blk, 6'd0);
            data_last  <= (n_bytes == 6'd1);
            state      <= STREAM;
          end
        end
        STREAM: begin
          if (data_valid && data_ready) begin
            if (data_last) begin
              data_valid <= 1'b0;
              data_last  <= 1'b0;
              data_out   <= '0;
              done       <= 1'b1;
              state      <= IDLE;
            end else begin
              cnt       <= cnt + 6'd1;
              data_out  <= byte_at(blk, cnt + 6'd1);
              data_last <= ((cnt + 6'd1) == (msg_len - 6'd1));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
